a_operand_skewer: RTL and testbench

- Upstream feeder for the systolic PE array.
- Accepts one N-element row vector of A operands per handshake and staggers it diagonally: lane i is delayed i extra cycles and drives `a_left`/`enleft` of array row i.
- Frames each tile of `k_len` vectors, broadcasts the tile's compute type alongside the data, drains the skew pipeline, and signals completion so the control logic can start the next tile.

---
 rtl/a_operand_skewer.sv | 159 +++++++++++++++
 tb/tb_a_operand_skewer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_operand_skewer.sv
// a_operand_skewer: staggers A-operand row vectors diagonally into the PE array.
// Build option SKEWER_ZERO_GATE_EN: zero lane_a on bubble cycles.

package params;
    typedef logic [3:0] full_type_t;
endpackage

module a_operand_skewer #(
    parameter int N     = 8,
    parameter int K_MAX = 256,
    parameter int DW    = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [$clog2(K_MAX+1)-1:0]               k_len,
    input  logic [$bits(params::full_type_t)-1:0]    type_in,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [N*DW-1:0]                          in_data,
    output logic [N*DW-1:0]                          lane_a,
    output logic [N-1:0]                             lane_en,
    output logic [N*$bits(params::full_type_t)-1:0]  lane_type,
    output logic                                     busy,
    output logic                                     done
);

    localparam int CW = $clog2(K_MAX+1);
    localparam int TW = $bits(params::full_type_t);
    localparam int FW = (N > 1) ? $clog2(N) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] klen_q, klen_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [TW-1:0] type_q, type_d;
    logic          zdone_q, zdone_d;
    logic          flush_done;
    logic          accept;

    assign in_ready = (state_q == STREAM);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid & in_ready;
    assign done     = flush_done | zdone_q;

    // Tile sequencing: launch, count accepts, then drain the skew
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        klen_d     = klen_q;
        type_d     = type_q;
        fcnt_d     = fcnt_q;
        zdone_d    = 1'b0;
        flush_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        klen_d  = k_len;
                        type_d  = type_in;
                        cnt_d   = '0;
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == klen_q) begin
                        fcnt_d  = '0;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (fcnt_q == FLUSH_LAST) begin
                    flush_done = 1'b1;
                    state_d    = IDLE;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and latched tile parameters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            klen_q  <= '0;
            fcnt_q  <= '0;
            type_q  <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            klen_q  <= klen_d;
            fcnt_q  <= fcnt_d;
            type_q  <= type_d;
            zdone_q <= zdone_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [i:0]    v_q;
        logic [i:0]    v_in;
        logic [DW-1:0] d_q  [i+1];
        logic [DW-1:0] d_in [i+1];

        for (genvar j = 0; j <= i; j++) begin : g_stage
            if (j == 0) begin : g_head
                assign v_in[j] = accept;
                assign d_in[j] = in_data[i*DW +: DW];
            end else begin : g_tail
                assign v_in[j] = v_q[j-1];
                assign d_in[j] = d_q[j-1];
            end
        end

        // Valid bits always shift; data only follows a valid entry
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    v_q[j] <= 1'b0;
                    d_q[j] <= '0;
                end
            end else begin
                for (int j = 0; j <= i; j++) begin
                    v_q[j] <= v_in[j];
                    if (v_in[j]) begin
                        d_q[j] <= d_in[j];
                    end
                end
            end
        end

        assign lane_en[i] = v_q[i];
`ifdef SKEWER_ZERO_GATE_EN
        assign lane_a[i*DW +: DW] = v_q[i] ? d_q[i] : '0;
`else
        assign lane_a[i*DW +: DW] = d_q[i];
`endif
        assign lane_type[i*TW +: TW] = type_q;
    end

endmodule

// File: tb/tb_a_operand_skewer.sv
// Bench for a_operand_skewer: table vectors, corner sequences and random
// traffic checked every cycle against a timeline model of the tile protocol.

module tb_a_operand_skewer;

    localparam int N     = 4;
    localparam int K_MAX = 256;
    localparam int DW    = 32;
    localparam int CW    = $clog2(K_MAX+1);
    localparam int TW    = $bits(params::full_type_t);
    localparam int MAXC  = 4096;

`ifdef SKEWER_ZERO_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [CW-1:0]   k_len = '0;
    logic [TW-1:0]   type_in = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] in_data = '0;
    logic [N*DW-1:0] lane_a;
    logic [N-1:0]    lane_en;
    logic [N*TW-1:0] lane_type;
    logic            busy;
    logic            done;

    a_operand_skewer #(.N(N), .K_MAX(K_MAX), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .type_in(type_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .lane_a(lane_a), .lane_en(lane_en),
        .lane_type(lane_type), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Timeline model: cycle c lies between edge c-1 and edge c.
    int            cyc = 0;
    bit            chk_en = 0;
    bit            streaming = 0;
    int            free_c = 0;
    int            cnt_m = 0;
    int            k_m = 0;
    int            s_m = 0;
    logic [TW-1:0] type_m = '0;
    bit            acc_v  [MAXC];
    bit            done_a [MAXC];
    bit            busy_a [MAXC];
    logic [DW-1:0] acc_d  [MAXC][N];
    logic [DW-1:0] last_d [N];

    task automatic cmp(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        int e;
        e = cyc;
        if (e >= MAXC - N - 2) begin
            $display("FAIL watchdog: cycle budget exhausted");
            $fatal(1, "watchdog");
        end
        if (rst) begin
            chk_en    = 1;
            streaming = 0;
            free_c    = e + 1;
            type_m    = '0;
            cnt_m     = 0;
            for (int i = 0; i < MAXC; i++) begin
                acc_v[i]  = 0;
                done_a[i] = 0;
                busy_a[i] = 0;
            end
            for (int l = 0; l < N; l++) last_d[l] = '0;
        end else if (!streaming && e >= free_c && start) begin
            if (k_len == '0) begin
                done_a[e+1] = 1;
            end else begin
                streaming = 1;
                cnt_m     = 0;
                k_m       = int'(k_len);
                type_m    = type_in;
                s_m       = e;
            end
        end else if (streaming && in_valid) begin
            acc_v[e] = 1;
            for (int l = 0; l < N; l++) acc_d[e][l] = in_data[l*DW +: DW];
            cnt_m++;
            if (cnt_m == k_m) begin
                streaming = 0;
                for (int c = s_m + 1; c <= e + N; c++) busy_a[c] = 1;
                done_a[e+N] = 1;
                free_c      = e + N + 1;
            end
        end
        cyc = e + 1;
    endtask

    task automatic check_cycle();
        logic [N-1:0]    een;
        logic [N*DW-1:0] ea;
        int e;
        int c;
        c   = cyc;
        een = '0;
        ea  = '0;
        for (int l = 0; l < N; l++) begin
            e = c - 1 - l;
            if (e >= 0 && acc_v[e]) begin
                een[l]         = 1'b1;
                ea[l*DW +: DW] = acc_d[e][l];
                last_d[l]      = acc_d[e][l];
            end else begin
                ea[l*DW +: DW] = GATED ? '0 : last_d[l];
            end
        end
        cmp("ctrl", {in_ready, busy, done},
            {streaming, streaming || busy_a[c], done_a[c]});
        cmp("lane_en", lane_en, een);
        cmp("lane_a", lane_a, ea);
        cmp("lane_type", lane_type, {N{type_m}});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) check_cycle();
    end

    typedef struct {
        bit           st;
        int           kl;
        int           ty;
        bit           iv;
        int           base;
        bit           rdy;
        bit           bsy;
        bit           dn;
        logic [N-1:0] en;
        int           a0;
        int           a3;
        int           lt;
    } row_t;

    row_t tbl[$];

    function automatic void add(bit st, int kl, int ty, bit iv, int base,
                                bit rdy, bit bsy, bit dn, logic [N-1:0] en,
                                int a0, int a3, int lt);
        row_t r;
        r = '{st, kl, ty, iv, base, rdy, bsy, dn, en, a0, a3, lt};
        tbl.push_back(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_data();
        for (int l = 0; l < N; l++) in_data[l*DW +: DW] = $urandom;
    endtask

    int dcount;
    int en_cnt [N];
    logic [DW-1:0] x0, x3;

    initial begin
        // Tile 1: three vectors back to back, stray starts ignored
        add(1, 3, 5, 0, 0,    0, 0, 0, 4'b0000, 0, 0,  0);
        add(0, 0, 0, 1, 1,    1, 1, 0, 4'b0000, 0, 0,  5);
        add(1, 2, 9, 1, 5,    1, 1, 0, 4'b0001, 1, 0,  5);
        add(0, 0, 0, 1, 9,    1, 1, 0, 4'b0011, 5, 0,  5);
        add(0, 0, 0, 0, 0,    0, 1, 0, 4'b0111, 9, 0,  5);
        add(0, 0, 0, 0, 0,    0, 1, 0, 4'b1110, 9, 4,  5);
        add(0, 0, 0, 0, 0,    0, 1, 0, 4'b1100, 9, 8,  5);
        add(1, 1, 9, 0, 0,    0, 1, 1, 4'b1000, 9, 12, 5);
        add(0, 0, 0, 0, 0,    0, 0, 0, 4'b0000, 9, 12, 5);
        // Tile 2: same data with a one-cycle gap after the first accept
        add(1, 3, 6, 0, 0,    0, 0, 0, 4'b0000, 9, 12, 5);
        add(0, 0, 0, 1, 1,    1, 1, 0, 4'b0000, 9, 12, 6);
        add(0, 0, 0, 0, 'h50, 1, 1, 0, 4'b0001, 1, 12, 6);
        add(0, 0, 0, 1, 5,    1, 1, 0, 4'b0010, 1, 12, 6);
        add(0, 0, 0, 1, 9,    1, 1, 0, 4'b0101, 5, 12, 6);
        add(0, 0, 0, 0, 0,    0, 1, 0, 4'b1011, 9, 4,  6);
        add(0, 0, 0, 0, 0,    0, 1, 0, 4'b0110, 9, 4,  6);
        add(0, 0, 0, 0, 0,    0, 1, 0, 4'b1100, 9, 8,  6);
        add(0, 0, 0, 0, 0,    0, 1, 1, 4'b1000, 9, 12, 6);
        add(0, 0, 0, 0, 0,    0, 0, 0, 4'b0000, 9, 12, 6);
        // Empty tile: done only
        add(1, 0, 3, 0, 0,    0, 0, 0, 4'b0000, 9, 12, 6);
        add(0, 0, 0, 0, 0,    0, 0, 1, 4'b0000, 9, 12, 6);
        add(0, 0, 0, 0, 0,    0, 0, 0, 4'b0000, 9, 12, 6);

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        foreach (tbl[r]) begin
            start    = tbl[r].st;
            k_len    = CW'(tbl[r].kl);
            type_in  = TW'(tbl[r].ty);
            in_valid = tbl[r].iv;
            for (int l = 0; l < N; l++) in_data[l*DW +: DW] = DW'(tbl[r].base + l);
            @(negedge clk);
            x0 = (GATED && !tbl[r].en[0]) ? '0 : DW'(tbl[r].a0);
            x3 = (GATED && !tbl[r].en[3]) ? '0 : DW'(tbl[r].a3);
            cmp($sformatf("tbl%0d_ctrl", r), {in_ready, busy, done},
                {tbl[r].rdy, tbl[r].bsy, tbl[r].dn});
            cmp($sformatf("tbl%0d_en", r), lane_en, tbl[r].en);
            cmp($sformatf("tbl%0d_a0", r), lane_a[0 +: DW], x0);
            cmp($sformatf("tbl%0d_a3", r), lane_a[3*DW +: DW], x3);
            cmp($sformatf("tbl%0d_type", r), lane_type, {N{TW'(tbl[r].ty == 0 ? tbl[r].lt : tbl[r].lt)}});
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Reset in the middle of a k_len=4 tile
        start   = 1'b1;
        k_len   = CW'(4);
        type_in = TW'(2);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        rand_data();
        tick();
        rand_data();
        tick();
        rst = 1'b1;
        rand_data();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        cmp("rst_zero", {lane_a, lane_en, lane_type, in_ready, busy, done}, '0);
        tick();
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
            tick();
        end
        cmp("rst_no_done", dcount, 0);

        // Fresh tile after the aborted one
        start   = 1'b1;
        k_len   = CW'(2);
        type_in = TW'(3);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        rand_data();
        tick();
        rand_data();
        tick();
        in_valid = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcount++;
            tick();
        end
        cmp("fresh_done", dcount, 1);

        // Full-size tile: no counter wrap
        start   = 1'b1;
        k_len   = CW'(K_MAX);
        type_in = TW'(7);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        dcount   = 0;
        for (int l = 0; l < N; l++) en_cnt[l] = 0;
        repeat (K_MAX + 12) begin
            rand_data();
            @(negedge clk);
            for (int l = 0; l < N; l++) if (lane_en[l]) en_cnt[l]++;
            if (done) dcount++;
            tick();
            if (!in_ready) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        for (int l = 0; l < N; l++) cmp($sformatf("kmax_en%0d", l), en_cnt[l], K_MAX);
        cmp("kmax_done", dcount, 1);

        // Random traffic against the model
        repeat (1500) begin
            start    = ($urandom % 6 == 0);
            k_len    = CW'($urandom % 10);
            type_in  = TW'($urandom);
            in_valid = ($urandom % 4 != 0);
            rst      = ($urandom % 500 == 0);
            rand_data();
            @(negedge clk);
            tick();
        end
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
